mat_operand_feeder: RTL and testbench

- Hardware source for the operand stream consumed by mat_mult: holds a 4x4 A matrix (9-bit unsigned) and a 4x4 B matrix (8-bit signed Q1.7).
- On start, issues 16 beats in row-major order. Each beat presents one A row and one B column, so mat_mult produces one result element per beat.
- Replaces bench-driven stimulus; sits between the host load interface and mat_mult.

---
 rtl/mat_pkg.sv | 25 ++
 rtl/mat_op_store.sv | 42 ++++
 rtl/mat_operand_feeder.sv | 113 +++++++++++
 tb/tb_mat_operand_feeder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared constants, state encoding and beat-index split for the matrix datapath
package mat_pkg;
    localparam int N     = 4;
    localparam int A_W   = 9;
    localparam int B_W   = 8;
    localparam int IDX_W = 2;
    localparam int K_W   = 4;

    localparam logic [K_W-1:0] K_LAST = K_W'(N * N - 1);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    // Row-major walk: upper bits select the A row, lower bits the B column.
    function automatic logic [IDX_W-1:0] k_row(input logic [K_W-1:0] k);
        return k[3:2];
    endfunction

    function automatic logic [IDX_W-1:0] k_col(input logic [K_W-1:0] k);
        return k[1:0];
    endfunction
endpackage

// File: rtl/mat_op_store.sv
// rtl/mat_op_store.sv - dual 4x4 operand register file, A row and B column read ports
module mat_op_store
    import mat_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      we,
    input  logic                      sel,
    input  logic [IDX_W-1:0]          row,
    input  logic [IDX_W-1:0]          col,
    input  logic [A_W-1:0]            data,
    input  logic [IDX_W-1:0]          a_idx,
    input  logic [IDX_W-1:0]          b_idx,
    output logic [N-1:0][A_W-1:0]     a_row,
    output logic [N-1:0][B_W-1:0]     b_col
);
    logic [A_W-1:0] a_mem [N][N];
    logic [B_W-1:0] b_mem [N][N];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_mem[r][c] <= '0;
                    b_mem[r][c] <= '0;
                end
            end
        end else if (we) begin
            if (sel)
                b_mem[row][col] <= data[B_W-1:0];
            else
                a_mem[row][col] <= data;
        end
    end

    always_comb begin
        for (int x = 0; x < N; x++) begin
            a_row[x] = a_mem[a_idx][x];
            b_col[x] = b_mem[x][b_idx];
        end
    end
endmodule

// File: rtl/mat_operand_feeder.sv
// rtl/mat_operand_feeder.sv - streams 16 A-row/B-column beats from loaded operands to mat_mult
module mat_operand_feeder
    import mat_pkg::*;
(
    input  logic             clk_80,
    input  logic             rst_80,
    input  logic             wr_en_80,
    input  logic             wr_sel_80,
    input  logic [1:0]       wr_row_80,
    input  logic [1:0]       wr_col_80,
    input  logic [A_W-1:0]   wr_data_80,
    input  logic             start_80,
    input  logic             hold_80,
    output logic [A_W-1:0]   A00_80,
    output logic [A_W-1:0]   A01_80,
    output logic [A_W-1:0]   A02_80,
    output logic [A_W-1:0]   A03_80,
    output logic [B_W-1:0]   B00_80,
    output logic [B_W-1:0]   B01_80,
    output logic [B_W-1:0]   B02_80,
    output logic [B_W-1:0]   B03_80,
    output logic             vld_80,
    output logic [1:0]       row_80,
    output logic [1:0]       col_80,
    output logic             busy_80,
    output logic             done_80
);
    state_t                state, state_nxt;
    logic [K_W-1:0]        k, k_nxt;
    logic                  beat;
    logic [N-1:0][A_W-1:0] a_rd, a_q;
    logic [N-1:0][B_W-1:0] b_rd, b_q;

    mat_op_store u_store (
        .clk   (clk_80),
        .rst   (rst_80),
        .we    (wr_en_80 && (state == IDLE)),
        .sel   (wr_sel_80),
        .row   (wr_row_80),
        .col   (wr_col_80),
        .data  (wr_data_80),
        .a_idx (k_row(k)),
        .b_idx (k_col(k)),
        .a_row (a_rd),
        .b_col (b_rd)
    );

    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            state <= IDLE;
            k     <= '0;
        end else begin
            state <= state_nxt;
            k     <= k_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        beat      = 1'b0;
        case (state)
            IDLE: begin
                if (start_80) begin
                    state_nxt = STREAM;
                    k_nxt     = '0;
                end
            end
            STREAM: begin
                if (!hold_80) begin
                    beat  = 1'b1;
                    k_nxt = k + 1'b1;
                    if (k == K_LAST)
                        state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Data/index registers only move on a beat, so stalls and idle gaps hold the last beat.
    always_ff @(posedge clk_80) begin
        if (rst_80) begin
            a_q     <= '0;
            b_q     <= '0;
            row_80  <= '0;
            col_80  <= '0;
            vld_80  <= 1'b0;
            busy_80 <= 1'b0;
            done_80 <= 1'b0;
        end else begin
            vld_80  <= beat;
            busy_80 <= (state_nxt != IDLE);
            done_80 <= (state == DONE);
            if (beat) begin
                a_q    <= a_rd;
                b_q    <= b_rd;
                row_80 <= k_row(k);
                col_80 <= k_col(k);
            end
        end
    end

    assign A00_80 = a_q[0];
    assign A01_80 = a_q[1];
    assign A02_80 = a_q[2];
    assign A03_80 = a_q[3];
    assign B00_80 = b_q[0];
    assign B01_80 = b_q[1];
    assign B02_80 = b_q[2];
    assign B03_80 = b_q[3];
endmodule

// File: tb/tb_mat_operand_feeder.sv
// tb/tb_mat_operand_feeder.sv - scoreboard bench for mat_operand_feeder
module tb_mat_operand_feeder;
    logic       clk_80 = 1'b0;
    logic       rst_80, wr_en_80, wr_sel_80, start_80, hold_80;
    logic [1:0] wr_row_80, wr_col_80;
    logic [8:0] wr_data_80;
    logic [8:0] A00_80, A01_80, A02_80, A03_80;
    logic [7:0] B00_80, B01_80, B02_80, B03_80;
    logic       vld_80, busy_80, done_80;
    logic [1:0] row_80, col_80;

    always #5 clk_80 = ~clk_80;

    mat_operand_feeder dut (
        .clk_80(clk_80), .rst_80(rst_80), .wr_en_80(wr_en_80), .wr_sel_80(wr_sel_80),
        .wr_row_80(wr_row_80), .wr_col_80(wr_col_80), .wr_data_80(wr_data_80),
        .start_80(start_80), .hold_80(hold_80),
        .A00_80(A00_80), .A01_80(A01_80), .A02_80(A02_80), .A03_80(A03_80),
        .B00_80(B00_80), .B01_80(B01_80), .B02_80(B02_80), .B03_80(B03_80),
        .vld_80(vld_80), .row_80(row_80), .col_80(col_80),
        .busy_80(busy_80), .done_80(done_80)
    );

    typedef struct packed {
        logic [3:0][8:0] a;
        logic [3:0][7:0] b;
        logic [1:0]      r;
        logic [1:0]      c;
    } beat_t;

    beat_t      exp_q[$];
    beat_t      last_exp, got_b, exp_b;
    int         n_cmp = 0, n_err = 0, cyc = 0;
    bit         mon_en = 0, prev_last = 0;
    int         done_seen = 0, vld_cnt = 0, first_beat_cyc = -1, done_cyc = -1;
    logic [8:0] ma [4][4];
    logic [7:0] mb [4][4];

    int unsigned pa [16] = '{10, 20, 30, 40, 50, 60, 70, 80, 90, 100, 110, 120, 130, 140, 150, 160};
    int unsigned pb [16] = '{13, 26, 38, 192, 77, 166, 154, 115, 102, 90, 77, 64, 205, 38, 230, 13};

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic beat_t sample();
        beat_t g;
        g.a[0] = A00_80; g.a[1] = A01_80; g.a[2] = A02_80; g.a[3] = A03_80;
        g.b[0] = B00_80; g.b[1] = B01_80; g.b[2] = B02_80; g.b[3] = B03_80;
        g.r = row_80;
        g.c = col_80;
        return g;
    endfunction

    always @(posedge clk_80) cyc <= cyc + 1;

    always @(negedge clk_80) begin
        if (mon_en) begin
            got_b = sample();
            if (vld_80) begin
                vld_cnt++;
                check("beat_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) begin
                    exp_b = exp_q.pop_front();
                    check("beat", 128'(got_b), 128'(exp_b));
                    last_exp = exp_b;
                    if (exp_b.r == 2'd0 && exp_b.c == 2'd0) first_beat_cyc = cyc;
                end
                check("vld_done_exclusive", 128'(done_80), 128'(0));
            end else begin
                check("held_outputs", 128'(got_b), 128'(last_exp));
            end
            if (done_80) begin
                done_seen++;
                done_cyc = cyc;
                check("done_after_last_beat", 128'(prev_last), 128'(1));
            end
            prev_last = vld_80 && row_80 == 2'd3 && col_80 == 2'd3;
        end
    end

    function automatic void model_write(input logic sel, input logic [1:0] r, input logic [1:0] c,
                                        input logic [8:0] d);
        if (sel) mb[r][c] = d[7:0];
        else     ma[r][c] = d;
    endfunction

    function automatic void push_stream();
        beat_t e;
        for (int k = 0; k < 16; k++) begin
            e.r = 2'(k / 4);
            e.c = 2'(k % 4);
            for (int x = 0; x < 4; x++) begin
                e.a[x] = ma[k / 4][x];
                e.b[x] = mb[x][k % 4];
            end
            exp_q.push_back(e);
        end
    endfunction

    // All driver tasks start and end #1 after a rising edge.
    task automatic write_elem(input logic sel, input logic [1:0] r, input logic [1:0] c, input logic [8:0] d);
        model_write(sel, r, c, d);
        wr_en_80 = 1; wr_sel_80 = sel; wr_row_80 = r; wr_col_80 = c; wr_data_80 = d;
        @(posedge clk_80); #1;
        wr_en_80 = 0;
    endtask

    task automatic load_plan();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                write_elem(1'b0, 2'(r), 2'(c), 9'(pa[r * 4 + c]));
                write_elem(1'b1, 2'(r), 2'(c), 9'(pb[r * 4 + c]));
            end
    endtask

    task automatic start_stream(input bit do_wr, input logic sel, input logic [8:0] d, output int ts);
        if (do_wr) begin
            model_write(sel, 2'd0, 2'd0, d);
            wr_en_80 = 1; wr_sel_80 = sel; wr_row_80 = 0; wr_col_80 = 0; wr_data_80 = d;
        end
        push_stream();
        vld_cnt = 0;
        start_80 = 1;
        @(posedge clk_80); #1;
        ts = cyc;
        start_80 = 0;
        wr_en_80 = 0;
    endtask

    task automatic wait_done(input int prev);
        int n = 0;
        while (done_seen == prev && n < 300) begin
            @(posedge clk_80); #1;
            n++;
        end
        check("stream_completes", 128'(done_seen), 128'(prev + 1));
        check("busy_low_after_done", 128'(busy_80), 128'(0));
    endtask

    initial begin
        int ts, d0, n;
        rst_80 = 1; wr_en_80 = 0; wr_sel_80 = 0; wr_row_80 = 0; wr_col_80 = 0;
        wr_data_80 = 0; start_80 = 0; hold_80 = 0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
        last_exp = '0;
        repeat (3) @(posedge clk_80);
        #1 rst_80 = 0;
        check("reset_outputs", 128'({sample(), vld_80, busy_80, done_80}), 128'(0));
        mon_en = 1;

        // Plain stream with latency checks
        load_plan();
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        check("busy_in_stream", 128'(busy_80), 128'(1));
        wait_done(d0);
        check("beat0_latency", 128'(first_beat_cyc - ts), 128'(1));
        check("done_latency", 128'(done_cyc - ts), 128'(17));
        check("vld_count", 128'(vld_cnt), 128'(16));

        // Three-cycle stall after beat 5
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        repeat (6) @(posedge clk_80);
        #1 hold_80 = 1;
        repeat (3) @(posedge clk_80);
        #1 hold_80 = 0;
        wait_done(d0);
        check("stall_done_latency", 128'(done_cyc - ts), 128'(20));
        check("stall_vld_count", 128'(vld_cnt), 128'(16));

        // Write and start while busy are both ignored
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        repeat (4) @(posedge clk_80);
        #1 wr_en_80 = 1; wr_sel_80 = 0; wr_row_80 = 0; wr_col_80 = 0; wr_data_80 = 9'd511; start_80 = 1;
        @(posedge clk_80);
        #1 wr_en_80 = 0; start_80 = 0;
        wait_done(d0);
        repeat (25) @(posedge clk_80);
        #1 check("single_done", 128'(done_seen), 128'(d0 + 1));
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        wait_done(d0);

        // Write together with start lands before beat 0; upper data bit ignored for B
        d0 = done_seen;
        start_stream(1, 1, 9'h180, ts);
        wait_done(d0);
        check("b00_sign", 128'(mb[0][0]), 128'(8'h80));

        // Reset during beat 9
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        n = 0;
        do begin
            @(negedge clk_80);
            n++;
        end while (!(vld_80 && row_80 == 2'd2 && col_80 == 2'd1) && n < 100);
        check("reached_beat9", 128'(n < 100), 128'(1));
        mon_en = 0;
        rst_80 = 1;
        @(negedge clk_80);
        check("reset_mid_stream", 128'({sample(), vld_80, busy_80, done_80}), 128'(0));
        rst_80 = 0;
        repeat (20) begin
            @(negedge clk_80);
            check("quiet_after_reset", 128'({vld_80, busy_80, done_80}), 128'(0));
        end
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin ma[r][c] = 0; mb[r][c] = 0; end
        exp_q.delete();
        last_exp = '0;
        prev_last = 0;
        mon_en = 1;
        @(posedge clk_80); #1;
        check("no_done_on_abort", 128'(done_seen), 128'(d0));
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        wait_done(d0);
        load_plan();
        d0 = done_seen;
        start_stream(0, 0, 0, ts);
        wait_done(d0);

        // Start on two consecutive idle cycles
        d0 = done_seen;
        push_stream();
        vld_cnt = 0;
        start_80 = 1;
        @(posedge clk_80); #1;
        ts = cyc;
        @(posedge clk_80); #1;
        start_80 = 0;
        wait_done(d0);
        repeat (25) @(posedge clk_80);
        #1;
        check("double_start_one_done", 128'(done_seen), 128'(d0 + 1));
        check("double_start_vld", 128'(vld_cnt), 128'(16));
        check("double_start_latency", 128'(done_cyc - ts), 128'(17));

        // Random operands, random stalls, stray writes/starts while busy
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++) begin
                    write_elem(1'b0, 2'(r), 2'(c), 9'($urandom));
                    write_elem(1'b1, 2'(r), 2'(c), 9'($urandom));
                end
            d0 = done_seen;
            start_stream(0, 0, 0, ts);
            n = 0;
            while (done_seen == d0 && n < 400) begin
                hold_80 = ($urandom_range(0, 3) == 0);
                if (busy_80) begin
                    wr_en_80 = ($urandom_range(0, 4) == 0);
                    start_80 = ($urandom_range(0, 4) == 0);
                    wr_sel_80 = 1'($urandom); wr_row_80 = 2'($urandom);
                    wr_col_80 = 2'($urandom); wr_data_80 = 9'($urandom);
                end else begin
                    wr_en_80 = 0;
                    start_80 = 0;
                end
                @(posedge clk_80); #1;
                n++;
            end
            hold_80 = 0; wr_en_80 = 0; start_80 = 0;
            check("rand_stream_done", 128'(done_seen), 128'(d0 + 1));
            check("rand_vld_count", 128'(vld_cnt), 128'(16));
        end

        repeat (4) @(posedge clk_80);
        #1 check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
